rtf_uart_rx_ng: RTL and testbench

Next-generation UART receiver for the rtfUart core. Generalised oversample ratio, FIFO depth and maximum word width. Uses an explicit bit-level state machine with optional 3-tick majority sampling, mark/space parity and single-entry break capture. Adds receive timeout, FIFO threshold and RTS flow-control outputs; sits between the baud generator and the rtfUart bus/register block.

---
 rtl/rtf_uart_pkg.sv | 29 ++
 rtl/rtf_uart_rx_ng_if.sv | 13 +
 rtl/rtf_uart_rx_fifo.sv | 55 +++++
 rtl/rtf_uart_rx_ng.sv | 204 ++++++++++++++++++++
 tb/tb_rtf_uart_rx_ng.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/rtf_uart_pkg.sv
// Shared types and encodings for the rtfUart receive path: FSM state codes,
// parity_ctrl encodings and the receive FIFO entry layout.
package rtf_uart_pkg;

    localparam int MAX_DATA_W = 32;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;
    localparam rx_state_t ST_BREAK  = 3'd5;

    // Every enabled parity mode has bit 0 set; all even codes mean "none".
    localparam logic [2:0] PAR_NONE  = 3'b000;
    localparam logic [2:0] PAR_ODD   = 3'b001;
    localparam logic [2:0] PAR_EVEN  = 3'b011;
    localparam logic [2:0] PAR_MARK  = 3'b101;
    localparam logic [2:0] PAR_SPACE = 3'b111;

    typedef struct packed {
        logic                  brk;
        logic                  perr;
        logic                  ferr;
        logic [MAX_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rtf_uart_rx_ng_if.sv
// Register-block bus between the rtfUart bus master and the receiver.
interface rtf_uart_rx_ng_if #(
    parameter int DATA_W = 32
) ();
    logic              cyc;
    logic              cs;
    logic              wr;
    logic [DATA_W+2:0] dout;
    logic              ack;

    modport master (output cyc, cs, wr, input dout, ack);
    modport slave  (input cyc, cs, wr, output dout, ack);
endinterface

// File: rtl/rtf_uart_rx_fifo.sv
// First-word-fall-through FIFO with occupancy count; a push into a full FIFO
// is only accepted when a pop happens in the same cycle.
module rtf_uart_rx_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   qcnt,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok, pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop & ~empty & ~flush;
    assign push_ok = push & (~full | pop_ok) & ~flush;
    assign drop    = push & full & ~pop_ok & ~flush;
    assign dout    = mem[rd_ptr_reg];
    assign qcnt    = count_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/rtf_uart_rx_ng.sv
// UART receiver: oversampled bit FSM with optional majority sampling, parity,
// break capture, receive FIFO, timeout/threshold interrupts and RTS output.
module rtf_uart_rx_ng
    import rtf_uart_pkg::*;
#(
    parameter int OVS        = 16,
    parameter int DEPTH      = 64,
    parameter int DATA_W     = 32,
    parameter int MAJORITY   = 1,
    parameter int RTS_MARGIN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    rtf_uart_rx_ng_if.slave        bus,
    input  logic                   fifo_clear,
    input  logic                   clear,
    input  logic                   clear_gerr,
    input  logic [2:0]             parity_ctrl,
    input  logic [5:0]             word_length,
    input  logic                   baud_ce,
    input  logic                   rxd,
    input  logic [$clog2(DEPTH):0] threshold,
    input  logic [7:0]             timeout_bits,
    output logic [$clog2(DEPTH):0] qcnt,
    output logic                   full,
    output logic                   empty,
    output logic                   overrun,
    output logic                   gerr,
    output logic                   thresh_irq,
    output logic                   timeout_irq,
    output logic                   rts_n,
    output logic                   bit_stream
);
    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] LAST_TICK   = TW'(OVS - 1);
    // With majority voting the decision waits one tick so mid+1 is available.
    localparam logic [TW-1:0] SAMPLE_TICK = TW'(OVS/2 - 1 + ((MAJORITY != 0) ? 1 : 0));

    logic              sync1_reg, sync2_reg;
    logic [1:0]        win_reg;
    rx_state_t         state_reg;
    logic [TW-1:0]     tick_reg, to_tick_reg;
    logic [5:0]        bit_idx_reg;
    logic [DATA_W-1:0] data_reg;
    logic              perr_reg, par_bit_reg;
    logic [7:0]        to_bits_reg;
    logic              overrun_reg, gerr_reg, thresh_reg, timeout_reg, rts_n_reg;

    logic              samp, start_det, at_sample, at_last, par_en, perr_calc;
    logic              stop_ferr, stop_brk, push, pop, drop, to_clr, to_hit;
    logic [5:0]        eff_wl;
    logic [DATA_W+2:0] fifo_din;
    rx_entry_t         entry;

    assign bit_stream = sync2_reg;
    assign samp = (MAJORITY != 0)
                ? ((win_reg[1] & win_reg[0]) | (win_reg[1] & sync2_reg) | (win_reg[0] & sync2_reg))
                : sync2_reg;
    assign start_det = baud_ce && (state_reg == ST_IDLE) && win_reg[0] && !sync2_reg;
    assign at_sample = (tick_reg == SAMPLE_TICK);
    assign at_last   = (tick_reg == LAST_TICK);
    assign par_en    = parity_ctrl[0];
    assign stop_ferr = ~samp;
    assign stop_brk  = ~samp && (data_reg == '0) && ~par_bit_reg;
    assign push      = baud_ce && (state_reg == ST_STOP) && at_sample && !clear;

    assign bus.ack = bus.cyc & bus.cs;
    assign pop     = bus.ack & ~bus.wr & ~empty;

    always_comb begin
        eff_wl = word_length;
        if (word_length < 6'd5)              eff_wl = 6'd5;
        else if (int'(word_length) > DATA_W) eff_wl = 6'(DATA_W);
    end

    always_comb begin
        perr_calc = 1'b0;
        case (parity_ctrl)
            PAR_ODD:   perr_calc = ~(^data_reg ^ samp);
            PAR_EVEN:  perr_calc = ^data_reg ^ samp;
            PAR_MARK:  perr_calc = ~samp;
            PAR_SPACE: perr_calc = samp;
            PAR_NONE:  perr_calc = 1'b0;
            default:   perr_calc = 1'b0;
        endcase
    end

    always_comb begin
        entry      = '0;
        entry.brk  = stop_brk;
        entry.perr = perr_reg;
        entry.ferr = stop_ferr;
        entry.data = MAX_DATA_W'(data_reg);
    end
    assign fifo_din = {entry.brk, entry.perr, entry.ferr, entry.data[DATA_W-1:0]};

    rtf_uart_rx_fifo #(.WIDTH(DATA_W + 3), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .flush(clear | fifo_clear),
        .push(push), .pop(pop), .din(fifo_din), .dout(bus.dout),
        .qcnt(qcnt), .full(full), .empty(empty), .drop(drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            win_reg   <= 2'b11;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            if (baud_ce) win_reg <= {win_reg[0], sync2_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg   <= ST_IDLE;
            tick_reg    <= '0;
            bit_idx_reg <= '0;
            data_reg    <= '0;
            perr_reg    <= 1'b0;
            par_bit_reg <= 1'b0;
        end else if (baud_ce) begin
            tick_reg <= at_last ? '0 : tick_reg + 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    tick_reg <= '0;
                    if (start_det) begin
                        state_reg   <= ST_START;
                        bit_idx_reg <= '0;
                        data_reg    <= '0;
                        perr_reg    <= 1'b0;
                        par_bit_reg <= 1'b0;
                    end
                end
                ST_START: begin
                    if (at_sample && samp) state_reg <= ST_IDLE;
                    else if (at_last)      state_reg <= ST_DATA;
                end
                ST_DATA: begin
                    if (at_sample)
                        data_reg <= data_reg | ({{(DATA_W-1){1'b0}}, samp} << bit_idx_reg);
                    if (at_last) begin
                        if (bit_idx_reg == eff_wl - 6'd1) state_reg <= par_en ? ST_PARITY : ST_STOP;
                        else bit_idx_reg <= bit_idx_reg + 6'd1;
                    end
                end
                ST_PARITY: begin
                    if (at_sample) begin
                        par_bit_reg <= samp;
                        perr_reg    <= perr_calc;
                    end
                    if (at_last) state_reg <= ST_STOP;
                end
                ST_STOP:  if (at_sample) state_reg <= stop_brk ? ST_BREAK : ST_IDLE;
                ST_BREAK: if (sync2_reg) state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    // Timeout counts whole bit times of idle line while data waits in the FIFO.
    assign to_clr = pop || start_det || empty;
    assign to_hit = baud_ce && (state_reg == ST_IDLE) && !to_clr && (to_tick_reg == LAST_TICK)
                 && (timeout_bits != 8'd0) && (to_bits_reg + 8'd1 == timeout_bits);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            overrun_reg <= 1'b0;
            gerr_reg    <= 1'b0;
            thresh_reg  <= 1'b0;
            rts_n_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            to_tick_reg <= '0;
            to_bits_reg <= '0;
        end else begin
            if (drop)            overrun_reg <= 1'b1;
            else if (clear_gerr) overrun_reg <= 1'b0;
            if (push && !drop && !fifo_clear && (perr_reg || stop_ferr)) gerr_reg <= 1'b1;
            else if (clear_gerr)                                        gerr_reg <= 1'b0;
            thresh_reg <= (threshold != '0) && (qcnt >= threshold);
            rts_n_reg  <= (int'(qcnt) >= DEPTH - RTS_MARGIN);
            if (to_clr) begin
                to_tick_reg <= '0;
                to_bits_reg <= '0;
            end else if (baud_ce && state_reg == ST_IDLE) begin
                if (to_tick_reg == LAST_TICK) begin
                    to_tick_reg <= '0;
                    if (to_bits_reg != 8'hFF) to_bits_reg <= to_bits_reg + 8'd1;
                end else begin
                    to_tick_reg <= to_tick_reg + 1'b1;
                end
            end
            if (pop || start_det || fifo_clear) timeout_reg <= 1'b0;
            else if (to_hit)                    timeout_reg <= 1'b1;
        end
    end

    assign overrun     = overrun_reg;
    assign gerr        = gerr_reg;
    assign thresh_irq  = thresh_reg;
    assign timeout_irq = timeout_reg;
    assign rts_n       = rts_n_reg;
endmodule

// File: tb/tb_rtf_uart_rx_ng.sv
// Scoreboard bench for rtf_uart_rx_ng: frames are driven on rxd, the expected
// FIFO entry is queued per frame and compared when the entry is read back.
module tb_rtf_uart_rx_ng;
    localparam int OVS        = 16;
    localparam int DEPTH      = 4;
    localparam int DATA_W     = 32;
    localparam int MAJORITY   = 1;
    localparam int RTS_MARGIN = 4;
    localparam int QW         = $clog2(DEPTH) + 1;
    localparam int BIT_CLKS   = 2 * OVS;

    logic clk = 1'b0, rst = 1'b1, fifo_clear = 1'b0, clear = 1'b0, clear_gerr = 1'b0;
    logic baud_ce = 1'b0, rxd = 1'b1;
    logic [2:0]    parity_ctrl  = 3'b000;
    logic [5:0]    word_length  = 6'd8;
    logic [QW-1:0] threshold    = '0;
    logic [7:0]    timeout_bits = 8'd0;
    logic [QW-1:0] qcnt;
    logic full, empty, overrun, gerr, thresh_irq, timeout_irq, rts_n, bit_stream;

    int vec_cnt = 0;
    int err_cnt = 0;
    int tick_count = 0;
    logic [DATA_W+2:0] exp_q[$];

    rtf_uart_rx_ng_if #(.DATA_W(DATA_W)) bus_if ();

    rtf_uart_rx_ng #(.OVS(OVS), .DEPTH(DEPTH), .DATA_W(DATA_W), .MAJORITY(MAJORITY),
                     .RTS_MARGIN(RTS_MARGIN)) dut (
        .clk(clk), .rst(rst), .bus(bus_if), .fifo_clear(fifo_clear), .clear(clear),
        .clear_gerr(clear_gerr), .parity_ctrl(parity_ctrl), .word_length(word_length),
        .baud_ce(baud_ce), .rxd(rxd), .threshold(threshold), .timeout_bits(timeout_bits),
        .qcnt(qcnt), .full(full), .empty(empty), .overrun(overrun), .gerr(gerr),
        .thresh_irq(thresh_irq), .timeout_irq(timeout_irq), .rts_n(rts_n),
        .bit_stream(bit_stream)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            baud_ce = ~baud_ce;
        end
    end

    always @(posedge clk) if (baud_ce) tick_count <= tick_count + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_char(input logic [31:0] d, input int nb, input bit use_par, input logic pbit);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (use_par) send_bit(pbit);
        send_bit(1'b1);
    endtask

    task automatic read_entry(input string tag);
        logic [DATA_W+2:0] exp;
        int n;
        n = 0;
        while (empty && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " avail"}, empty, 0);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        chk(tag, bus_if.dout, exp);
        bus_if.cyc = 1'b1;
        bus_if.cs  = 1'b1;
        bus_if.wr  = 1'b0;
        @(negedge clk);
        bus_if.cyc = 1'b0;
        bus_if.cs  = 1'b0;
    endtask

    task automatic pulse_clear_gerr();
        clear_gerr = 1'b1;
        @(negedge clk);
        clear_gerr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t0, t1, n;
        bus_if.cyc = 1'b0;
        bus_if.cs  = 1'b0;
        bus_if.wr  = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst empty", empty, 1);
        chk("rst qcnt", qcnt, 0);
        chk("rst overrun", overrun, 0);
        chk("rst gerr", gerr, 0);
        chk("rst thresh_irq", thresh_irq, 0);
        chk("rst timeout_irq", timeout_irq, 0);
        chk("rst rts_n", rts_n, 0);
        chk("rst bit_stream", bit_stream, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 single character
        exp_q.push_back({3'b000, 32'h55});
        send_char(32'h55, 8, 0, 1'b0);
        chk("8n1 qcnt", qcnt, 1);
        read_entry("8n1 0x55");
        chk("8n1 empty after pop", empty, 1);

        // 7E1: 0x41 has two ones (parity 0 correct), 0x43 has three (parity 0 wrong)
        parity_ctrl = 3'b011;
        word_length = 6'd7;
        exp_q.push_back({3'b000, 32'h41});
        send_char(32'h41, 7, 1, 1'b0);
        chk("7e1 good gerr", gerr, 0);
        exp_q.push_back({3'b010, 32'h43});
        send_char(32'h43, 7, 1, 1'b0);
        chk("7e1 bad gerr", gerr, 1);
        read_entry("7e1 0x41");
        read_entry("7e1 0x43 perr");
        pulse_clear_gerr();
        chk("clear_gerr gerr", gerr, 0);

        // short low glitch is a false start
        parity_ctrl = 3'b000;
        word_length = 6'd8;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        chk("glitch qcnt", qcnt, 0);
        chk("glitch empty", empty, 1);

        // long break then a clean character
        rxd = 1'b0;
        repeat (30 * BIT_CLKS) @(negedge clk);
        chk("break qcnt", qcnt, 1);
        chk("break gerr", gerr, 1);
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        exp_q.push_back({3'b101, 32'h0});
        exp_q.push_back({3'b000, 32'hA5});
        send_char(32'hA5, 8, 0, 1'b0);
        read_entry("break entry");
        read_entry("after break 0xA5");
        pulse_clear_gerr();

        // fill past depth
        threshold = QW'(2);
        for (int i = 0; i < 5; i++) begin
            if (i < DEPTH) exp_q.push_back({3'b000, 32'h11 + 32'(i)});
            send_char(32'h11 + 32'(i), 8, 0, 1'b0);
        end
        chk("ovr qcnt", qcnt, DEPTH);
        chk("ovr full", full, 1);
        chk("ovr overrun", overrun, 1);
        chk("ovr rts_n", rts_n, 1);
        chk("ovr thresh_irq", thresh_irq, 1);
        for (int i = 0; i < DEPTH; i++) read_entry($sformatf("ovr entry %0d", i));
        @(negedge clk);
        chk("ovr drained empty", empty, 1);
        chk("ovr thresh_irq low", thresh_irq, 0);
        chk("ovr overrun kept", overrun, 1);
        pulse_clear_gerr();
        chk("ovr overrun cleared", overrun, 0);
        threshold = '0;

        // receive timeout: 4 bit times after the stop sample pushes the entry
        timeout_bits = 8'd4;
        exp_q.push_back({3'b000, 32'h3C});
        t0 = 0;
        fork
            send_char(32'h3C, 8, 0, 1'b0);
            begin
                n = 0;
                while (empty && n < 4000) begin
                    @(negedge clk);
                    n++;
                end
                t0 = tick_count;
                chk("to early irq", timeout_irq, 0);
            end
        join
        n = 0;
        while (!timeout_irq && n < 4000) begin
            @(negedge clk);
            n++;
        end
        t1 = tick_count;
        chk("to irq raised", timeout_irq, 1);
        chk("to tick distance", 64'(t1 - t0), 64'(4 * OVS));
        read_entry("to entry 0x3C");
        chk("to irq cleared by pop", timeout_irq, 0);
        timeout_bits = 8'd0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
